// File: rtl/hpc2_rand_source.sv
// Fresh-randomness source for a bank of masked HPC2 gadgets: a seeded 64-bit
// LFSR, unrolled RW steps per advance, with seed handshake, warm-up and reseed hint.
module hpc2_rand_source #(
    parameter int security_order  = 1,
    parameter int NUM_GADGETS     = 1,
    parameter int WARMUP          = 64,
    parameter int RESEED_INTERVAL = 0,
    localparam int RND = security_order * (security_order + 1) / 2,
    localparam int RW  = RND * NUM_GADGETS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   seed_in,
    input  logic          seed_valid,
    output logic          seed_ready,
    input  logic          en,
    output logic [RW-1:0] r,
    output logic          r_valid,
    output logic          reseed_req
);

    localparam int WCW = $clog2(WARMUP + 1);
    localparam int CCW = (RESEED_INTERVAL < 1) ? 1 : $clog2(RESEED_INTERVAL + 1);
    localparam logic [WCW-1:0] WARMUP_LAST = WCW'(WARMUP - 1);
    localparam logic [CCW-1:0] WORD_MAX    = CCW'(RESEED_INTERVAL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [63:0]    lfsr;
    logic [63:0]    lfsr_walk;
    logic [RW-1:0]  r_step;
    logic [WCW-1:0] warm_cnt;
    logic [CCW-1:0] word_cnt;
    logic           accept;
    logic           advance;

    // NOTE: blocking assignments are correct here; lfsr_walk is a scratch
    // variable threaded through the unrolled loop, each iteration seeing the last.
    always_comb begin
        lfsr_walk = lfsr;
        r_step    = '0;
        for (int j = 0; j < RW; j++) begin
            r_step[j] = lfsr_walk[63];
            lfsr_walk = {lfsr_walk[62:0],
                         lfsr_walk[63] ^ lfsr_walk[62] ^ lfsr_walk[60] ^ lfsr_walk[59]};
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        seed_ready = 1'b0;
        r_valid    = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                seed_ready = 1'b1;
            end
            ST_WARMUP: begin
                advance = 1'b1;
                if (warm_cnt == WARMUP_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                seed_ready = 1'b1;
                r_valid    = 1'b1;
                advance    = en;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A seed accept takes priority over a same-edge advance.
        accept = seed_valid & seed_ready;
        if (accept) begin
            state_nxt = ST_WARMUP;
            advance   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lfsr       <= '0;
            r          <= '0;
            warm_cnt   <= '0;
            word_cnt   <= '0;
            reseed_req <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // An all-zero state would lock the LFSR up, so substitute 1.
                lfsr       <= (seed_in == 64'd0) ? 64'd1 : seed_in;
                warm_cnt   <= '0;
                word_cnt   <= '0;
                reseed_req <= 1'b0;
            end else if (advance) begin
                lfsr <= lfsr_walk;
                r    <= r_step;
                if (state == ST_WARMUP) warm_cnt <= warm_cnt + 1'b1;
                if (state == ST_RUN && RESEED_INTERVAL != 0 && word_cnt != WORD_MAX) begin
                    word_cnt <= word_cnt + 1'b1;
                    if (word_cnt == WORD_MAX - 1'b1) reseed_req <= 1'b1;
                end
            end
        end
    end

endmodule
